bcd_tens_display: RTL and testbench
===================================

# bcd_tens_display

Downstream stage of the single-digit decade counter. Consumes its 4-bit count and carry, and keeps a tens digit that steps on each carry event in the direction given by up_down. Time-multiplexes the ones and tens digits onto one shared 7-segment bus with active-low digit enables. Together with the decade counter it forms a 00–99 up/down counter with display.

## Interface
- REFRESH_DIV, default 4: clock cycles each digit is held on the bus; legal range 2..65535.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- count  input  4  ones digit from the decade counter; 0..9 valid.
- carry  input  1  carry from the decade counter; level signal, edge-detected here.
- up_down  input  1  direction: 1 = tens increments, 0 = tens decrements.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- an  output  2  digit enables, active-low: an[0] = ones, an[1] = tens.
- tens  output  4  current tens digit, 0..9.
- wrap  output  1  one-cycle pulse when tens wraps (9→0 going up, 0→9 going down).

## Operation
- **Carry edge detect**
  - carry_d is a register holding last cycle's carry.
  - carry_evt = carry & ~carry_d.
  - A carry held high for N cycles produces exactly one event.
- **Tens counter**
  - On carry_evt, tens steps by ±1 per the up_down value sampled on the same edge.
  - Up: 9→0 with wrap=1. Down: 0→9 with wrap=1.
  - Otherwise tens holds and wrap=0.
- **Refresh counter**
  - ref_cnt counts 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and toggles sel (0 = ones, 1 = tens).
- **Output register**
  - Each cycle, an and seg are loaded from the current sel.
  - sel=0: an=2'b10, seg=decode(count).
  - sel=1: an=2'b01, seg=decode(tens).
- **Decode**
  - 0..9 use standard patterns, e.g. 0=7'h3F, 1=7'h06, 8=7'h7F, 9=7'h6F.
  - count values 10..15 decode to dash, 7'h40 (segment g only).
  - tens never leaves 0..9.
- **Reset values:** tens=0, wrap=0, carry_d=0, ref_cnt=0, sel=0, seg=7'h00, an=2'b11 (all digits dark).
- **Reset mid-operation:** all state returns to reset values asynchronously. No carry event is generated by carry already being high when reset releases; carry_d is reloaded from carry on the first clock edge after release.

## Timing
- tens and wrap change on the first rising edge at which carry_evt=1, so latency is 1 cycle from carry going high.
- wrap is high for exactly that one cycle.
- sel dwell time is REFRESH_DIV cycles; the full refresh period is 2×REFRESH_DIV cycles.
- an and seg are registered: they follow sel and source values with 1-cycle latency. A change in count or tens appears on seg one cycle later, but only while its digit is selected.
- First edge after reset release: an=2'b10, showing the ones digit.
- A carry_evt in the same cycle as an up_down change uses the up_down value at that edge.
- A carry_evt in the same cycle as a sel toggle has no interaction between the two.

## Configuration
- BCD_TENS_BLANK_EN
  - Defined: when sel=1 and tens=0, seg=7'h00 while an[1] is still driven low (leading-zero blanking). wrap and tens are unaffected.
  - Undefined: a tens digit of 0 displays as 7'h3F.

## Structure
- Shared package holds:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - digit-enable constants AN_ONES=2'b10, AN_TENS=2'b01, AN_OFF=2'b11;
  - a DIGIT_MAX=9 constant.
- One sub-module, seg7_decode: purely combinational, 4-bit value in, 7-bit pattern out. Instantiated once, fed by a sel-controlled mux.
- The edge detect, tens counter, refresh counter and output register live in bcd_tens_display.

## Test plan
- **Reset:** hold reset=1 with carry=1 and count=5.
  - During reset: seg=0, an=2'b11, tens=0, wrap=0.
  - After release: no tens change occurs.
- **Count up:** up_down=1, ten carry pulses of 1 cycle each.
  - tens goes 1,2,…,9,0.
  - wrap pulses once, on the 10th pulse only.
- **Count down:** up_down=0 from tens=0, one carry pulse.
  - tens=9, with a 1-cycle wrap.
  - A second pulse gives tens=8 and no wrap.
- **Held carry:** carry held high for 7 cycles → tens advances exactly once.
- **Multiplexing:** REFRESH_DIV=4, count=3, tens=7.
  - an alternates 2'b10 / 2'b01 every 4 cycles.
  - seg alternates 7'h4F / 7'h07 in lockstep.
  - count=12 shows 7'h40 in the ones slot.
- **Blanking:** with BCD_TENS_BLANK_EN defined and tens=0, the tens slot shows seg=7'h00 with an=2'b01. Without the macro, the tens slot shows 7'h3F.

Source files
------------

// File: rtl/bcd_tens_display_pkg.sv
// Shared constants for the tens-digit display stage: 7-segment patterns,
// active-low digit enables and the tens step helper.
package bcd_tens_display_pkg;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Segment bit order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  typedef enum logic {
    SEL_ONES = 1'b0,
    SEL_TENS = 1'b1
  } digit_sel_e;

  typedef struct packed {
    logic [3:0] digit;
    logic       wrap;
  } step_result_t;

  // One decimal step in the requested direction, flagging the 9<->0 wrap
  function automatic step_result_t digit_step(input logic [3:0] digit, input logic up);
    step_result_t r;
    r.wrap = 1'b0;
    if (up) begin
      if (digit >= DIGIT_MAX) begin
        r.digit = 4'd0;
        r.wrap  = 1'b1;
      end else begin
        r.digit = digit + 4'd1;
      end
    end else begin
      if (digit == 4'd0) begin
        r.digit = DIGIT_MAX;
        r.wrap  = 1'b1;
      end else begin
        r.digit = digit - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_tens_display_seg7_decode.sv
// Combinational BCD to 7-segment decoder; out-of-range codes show a dash.
module seg7_decode
  import bcd_tens_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    unique case (value)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_tens_display.sv
// Tens digit driven by the decade counter's carry, plus two-digit multiplexed
// 7-segment output. Define BCD_TENS_BLANK_EN for leading-zero blanking of tens.
module bcd_tens_display
  import bcd_tens_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       carry,
  input  logic       up_down,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] tens,
  output logic       wrap
);

  localparam logic [15:0] REF_TC = 16'(REFRESH_DIV - 1);

  logic         carry_d_reg;
  logic         armed_reg;
  logic         carry_evt;
  logic [3:0]   tens_reg, tens_next;
  logic         wrap_reg, wrap_next;
  logic [15:0]  ref_cnt_reg, ref_cnt_next;
  digit_sel_e   sel_reg, sel_next;
  logic [6:0]   seg_reg, seg_next;
  logic [1:0]   an_reg, an_next;
  logic [3:0]   dec_value;
  logic [6:0]   dec_pattern;
  logic         blank;
  step_result_t step;

  // armed_reg masks the first edge after reset so a carry already high at
  // release is absorbed into carry_d instead of counting as an event
  assign carry_evt = carry & ~carry_d_reg & armed_reg;
  assign step      = digit_step(tens_reg, up_down);

  always_comb begin
    tens_next = tens_reg;
    wrap_next = 1'b0;
    if (carry_evt) begin
      tens_next = step.digit;
      wrap_next = step.wrap;
    end
  end

  always_comb begin
    ref_cnt_next = ref_cnt_reg + 16'd1;
    sel_next     = sel_reg;
    if (ref_cnt_reg == REF_TC) begin
      ref_cnt_next = 16'd0;
      sel_next     = (sel_reg == SEL_ONES) ? SEL_TENS : SEL_ONES;
    end
  end

  assign dec_value = (sel_reg == SEL_TENS) ? tens_reg : count;

  seg7_decode u_decode (
    .value   (dec_value),
    .pattern (dec_pattern)
  );

`ifdef BCD_TENS_BLANK_EN
  assign blank = (sel_reg == SEL_TENS) && (tens_reg == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_next  = (sel_reg == SEL_TENS) ? AN_TENS : AN_ONES;
    seg_next = blank ? SEG_OFF : dec_pattern;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_d_reg <= 1'b0;
      armed_reg   <= 1'b0;
      tens_reg    <= 4'd0;
      wrap_reg    <= 1'b0;
      ref_cnt_reg <= 16'd0;
      sel_reg     <= SEL_ONES;
      seg_reg     <= SEG_OFF;
      an_reg      <= AN_OFF;
    end else begin
      carry_d_reg <= carry;
      armed_reg   <= 1'b1;
      tens_reg    <= tens_next;
      wrap_reg    <= wrap_next;
      ref_cnt_reg <= ref_cnt_next;
      sel_reg     <= sel_next;
      seg_reg     <= seg_next;
      an_reg      <= an_next;
    end
  end

  assign seg  = seg_reg;
  assign an   = an_reg;
  assign tens = tens_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_bcd_tens_display.sv
// Directed bench for bcd_tens_display with REFRESH_DIV=4.
module tb_bcd_tens_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count;
  logic       carry;
  logic       up_down;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] tens;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // clock edges since reset release

  bcd_tens_display #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .carry   (carry),
    .up_down (up_down),
    .seg     (seg),
    .an      (an),
    .tens    (tens),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [6:0] ref_dec(input logic [3:0] v);
    logic [6:0] tbl [0:9];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v <= 4'd9) ? tbl[v] : 7'h40;
  endfunction

  // One-cycle carry pulse, then check tens/wrap and that wrap drops again
  task automatic pulse(input logic [3:0] exp_tens, input logic exp_wrap);
    carry = 1'b1;
    tick();
    chk($sformatf("pulse_tens_%0d", exp_tens), {4'd0, tens}, {4'd0, exp_tens});
    chk($sformatf("pulse_wrap_%0d", exp_tens), {7'd0, wrap}, {7'd0, exp_wrap});
    carry = 1'b0;
    tick();
    chk("wrap_drop", {7'd0, wrap}, 8'd0);
  endtask

  // Output at edge k was loaded from the select value after edge k-1
  task automatic mux_check(input int n, input logic [3:0] exp_tens);
    logic       s;
    logic [6:0] es;
    for (int i = 0; i < n; i++) begin
      tick();
      s = (((cyc - 1) / 4) % 2) == 1;
      if (s) begin
        es = ref_dec(exp_tens);
`ifdef BCD_TENS_BLANK_EN
        if (exp_tens == 4'd0) es = 7'h00;
`endif
      end else begin
        es = ref_dec(count);
      end
      chk($sformatf("mux_an_c%0d", cyc), {6'd0, an}, {6'd0, (s ? 2'b01 : 2'b10)});
      chk($sformatf("mux_seg_c%0d", cyc), {1'b0, seg}, {1'b0, es});
    end
  endtask

  initial begin
    reset   = 1'b1;
    carry   = 1'b1;
    count   = 4'd5;
    up_down = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg",  {1'b0, seg},  8'h00);
    chk("rst_an",   {6'd0, an},   8'h03);
    chk("rst_tens", {4'd0, tens}, 8'h00);
    chk("rst_wrap", {7'd0, wrap}, 8'h00);

    // Release with carry still high: no event may result
    reset = 1'b0;
    cyc   = 0;
    tick();
    chk("first_an",  {6'd0, an},  8'h02);
    chk("first_seg", {1'b0, seg}, 8'h6D);
    chk("rel_tens0", {4'd0, tens}, 8'h00);
    tick();
    chk("rel_tens1", {4'd0, tens}, 8'h00);
    chk("rel_wrap",  {7'd0, wrap}, 8'h00);
    carry = 1'b0;
    tick();

    // Count up through a full decade
    for (int i = 1; i <= 10; i++)
      pulse(4'(i % 10), i == 10);

    // Count down from 0
    up_down = 1'b0;
    pulse(4'd9, 1'b1);
    pulse(4'd8, 1'b0);

    // Held carry advances exactly once
    up_down = 1'b1;
    carry   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("held_tens_%0d", i), {4'd0, tens}, 8'h09);
      chk($sformatf("held_wrap_%0d", i), {7'd0, wrap}, 8'h00);
    end
    carry = 1'b0;
    tick();

    // Down to 7, with up_down changed on the same edge as the event
    carry   = 1'b1;
    up_down = 1'b0;
    tick();
    chk("dir_same_edge", {4'd0, tens}, 8'h08);
    carry = 1'b0;
    tick();
    pulse(4'd7, 1'b0);

    // Multiplexing: ones=3, tens=7, then a dash in the ones slot
    count = 4'd3;
    mux_check(16, 4'd7);
    count = 4'd12;
    mux_check(8, 4'd7);

    // Asynchronous reset mid-cycle with carry held high
    count = 4'd3;
    carry = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_tens", {4'd0, tens}, 8'h00);
    chk("async_an",   {6'd0, an},   8'h03);
    chk("async_seg",  {1'b0, seg},  8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    tick();
    chk("rerel_tens0", {4'd0, tens}, 8'h00);
    tick();
    chk("rerel_tens1", {4'd0, tens}, 8'h00);
    carry = 1'b0;

    // Tens digit of zero: blanked or shown as 0 depending on build
    mux_check(8, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
